// File: rtl/nano_pkg.sv
// Shared constants and FSM state encoding for the nano memory controller.
package nano_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/nano_mem_mux.sv
// RUN-phase memory arbitration (CPU has priority over debug).
// Also holds the saturating counter of denied debug cycles.
module nano_mem_mux
  import nano_pkg::*;
#(
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned DW = DATA_W
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_ce,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_dataW,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [AW-1:0] mux_address,
  output logic          mux_we,
  output logic [DW-1:0] mux_dataW,
  output logic          dbg_gnt,
  output logic [7:0]    dbg_wait_cnt
);

  always_comb begin
    mux_address = cpu_address;
    mux_we      = 1'b0;
    mux_dataW   = cpu_dataW;
    dbg_gnt     = 1'b0;
    if (run) begin
      if (cpu_ce) begin
        mux_we = cpu_we;
      end else if (dbg_req) begin
        dbg_gnt     = 1'b1;
        mux_address = dbg_addr;
        mux_we      = dbg_we;
        mux_dataW   = dbg_wdata;
      end
    end
  end

  // Outside RUN the grant is held low, so pending requests are counted there too.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      dbg_wait_cnt <= '0;
    end else if (dbg_req && !dbg_gnt) begin
      if (dbg_wait_cnt != '1) dbg_wait_cnt <= dbg_wait_cnt + 8'd1;
    end else begin
      dbg_wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/nano_mem_ctrl.sv
// Program-loading memory controller: LOAD fills memory from a stream while
// the CPU is held in reset, RELEASE spends one cycle, RUN arbitrates CPU/debug.
module nano_mem_ctrl
  import nano_pkg::*;
#(
  parameter int unsigned            ADDR_W    = nano_pkg::ADDR_W,
  parameter int unsigned            DATA_W    = nano_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]      LOAD_BASE = '0
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              cpu_rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_ce,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_dataW,
  output logic [DATA_W-1:0] cpu_dataR,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [7:0]        dbg_wait_cnt,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_dataW,
  input  logic [DATA_W-1:0] mem_dataR,
  output logic [1:0]        state_o
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              run;
  logic [ADDR_W-1:0] mux_address;
  logic              mux_we;
  logic [DATA_W-1:0] mux_dataW;

  assign run = (state == ST_RUN);

  nano_mem_mux #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_mux (
    .ck          (ck),
    .rst         (rst),
    .run         (run),
    .cpu_address (cpu_address),
    .cpu_ce      (cpu_ce),
    .cpu_we      (cpu_we),
    .cpu_dataW   (cpu_dataW),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .mux_address (mux_address),
    .mux_we      (mux_we),
    .mux_dataW   (mux_dataW),
    .dbg_gnt     (dbg_gnt),
    .dbg_wait_cnt(dbg_wait_cnt)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= ST_LOAD;
      ptr   <= LOAD_BASE;
    end else begin
      state <= state_nxt;
      if (state == ST_LOAD && load_valid) ptr <= ptr + 1'b1;
      else if (run && reload)             ptr <= LOAD_BASE;
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_rst     = 1'b1;
    load_ready  = 1'b0;
    mem_address = ptr;
    mem_we      = 1'b0;
    mem_dataW   = load_data;
    unique case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        if (load_valid && (load_last || ptr == '1)) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_RUN;
      ST_RUN: begin
        cpu_rst     = 1'b0;
        mem_address = mux_address;
        mem_we      = mux_we;
        mem_dataW   = mux_dataW;
        if (reload) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
    // Reset must suppress the write in the very cycle it is asserted.
    if (!rst) mem_we = 1'b0;
  end

  assign cpu_dataR = mem_dataR;
  assign dbg_rdata = mem_dataR;
  assign state_o   = state;

endmodule

// File: tb/tb_nano_mem_ctrl.sv
// Directed self-checking bench for nano_mem_ctrl with a behavioural RAM.
module tb_nano_mem_ctrl;

  logic        ck = 1'b0;
  logic        rst;
  logic        load_valid, load_last, reload;
  logic [15:0] load_data;
  logic        load_ready, cpu_rst;
  logic [7:0]  cpu_address;
  logic        cpu_ce, cpu_we;
  logic [15:0] cpu_dataW, cpu_dataR;
  logic        dbg_req, dbg_we, dbg_gnt;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic [7:0]  dbg_wait_cnt;
  logic [7:0]  mem_address;
  logic        mem_we;
  logic [15:0] mem_dataW, mem_dataR;
  logic [1:0]  state_o;

  logic [15:0] mem [256];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 ck = ~ck;

  always @(posedge ck) if (mem_we) mem[mem_address] <= mem_dataW;
  assign mem_dataR = mem[mem_address];

  nano_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .LOAD_BASE(8'h00)) dut (
    .ck(ck), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .reload(reload), .cpu_rst(cpu_rst),
    .cpu_address(cpu_address), .cpu_ce(cpu_ce), .cpu_we(cpu_we),
    .cpu_dataW(cpu_dataW), .cpu_dataR(cpu_dataR),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_wait_cnt(dbg_wait_cnt),
    .mem_address(mem_address), .mem_we(mem_we), .mem_dataW(mem_dataW),
    .mem_dataR(mem_dataR), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b1; load_data = 16'hDEAD; load_last = 1'b0;
    reload = 1'b0; cpu_address = '0; cpu_ce = 1'b0; cpu_we = 1'b0;
    cpu_dataW = '0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #3;
    check("rst_state", state_o, 2'd0);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_dbg_gnt", dbg_gnt, 1'b0);
    check("rst_mem_address", mem_address, 8'h00);
    check("rst_wait_cnt", dbg_wait_cnt, 8'd0);
    tick(); tick();
    rst = 1'b1; load_valid = 1'b0;

    // Three-word program, last flagged
    load_valid = 1'b1; load_data = 16'h4000; load_last = 1'b0; #1;
    check("ld0_we", mem_we, 1'b1);
    check("ld0_addr", mem_address, 8'h00);
    tick();
    load_data = 16'h4111; #1;
    check("ld1_addr", mem_address, 8'h01);
    tick();
    load_data = 16'h0093; load_last = 1'b1; #1;
    check("ld2_addr", mem_address, 8'h02);
    tick();
    load_valid = 1'b0; load_last = 1'b0; #1;
    check("rel_state", state_o, 2'd1);
    check("rel_cpu_rst", cpu_rst, 1'b1);
    check("rel_load_ready", load_ready, 1'b0);
    check("rel_mem_we", mem_we, 1'b0);
    tick();
    check("run_state", state_o, 2'd2);
    check("run_cpu_rst", cpu_rst, 1'b0);
    check("mem0", mem[0], 16'h4000);
    check("mem1", mem[1], 16'h4111);
    check("mem2", mem[2], 16'h0093);

    // CPU holds memory while debug waits five cycles
    cpu_ce = 1'b1; cpu_address = 8'h01; dbg_req = 1'b1; dbg_addr = 8'h02; #1;
    check("cpu_read", cpu_dataR, 16'h4111);
    for (int i = 0; i < 5; i++) begin
      check("deny_gnt", dbg_gnt, 1'b0);
      tick();
    end
    check("wait_5", dbg_wait_cnt, 8'd5);
    cpu_ce = 1'b0; #1;
    check("grant6", dbg_gnt, 1'b1);
    check("grant6_rdata", dbg_rdata, 16'h0093);
    tick();
    check("wait_clear", dbg_wait_cnt, 8'd0);

    // Debug write then read of mem[10]
    dbg_we = 1'b1; dbg_addr = 8'd10; dbg_wdata = 16'h000A; #1;
    check("dbgw_we", mem_we, 1'b1);
    check("dbgw_addr", mem_address, 8'd10);
    tick();
    dbg_we = 1'b0; #1;
    check("dbgr_gnt", dbg_gnt, 1'b1);
    check("dbgr_data", dbg_rdata, 16'h000A);
    dbg_req = 1'b0;

    // CPU write and readback, then idle cycle has no write
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_address = 8'd20; cpu_dataW = 16'h1234; #1;
    check("cpuw_we", mem_we, 1'b1);
    tick();
    cpu_we = 1'b0; #1;
    check("cpuw_read", cpu_dataR, 16'h1234);
    cpu_ce = 1'b0; #1;
    check("idle_we", mem_we, 1'b0);

    // Wait counter saturation
    cpu_ce = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    check("wait_sat", dbg_wait_cnt, 8'd255);
    dbg_req = 1'b0; tick();
    check("wait_drop", dbg_wait_cnt, 8'd0);

    // Reload with a concurrent granted debug write
    cpu_ce = 1'b0; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd30;
    dbg_wdata = 16'hBEEF; reload = 1'b1; #1;
    check("rld_gnt", dbg_gnt, 1'b1);
    tick();
    reload = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; #1;
    check("rld_state", state_o, 2'd0);
    check("rld_cpu_rst", cpu_rst, 1'b1);
    check("rld_load_ready", load_ready, 1'b1);
    check("rld_addr", mem_address, 8'h00);
    check("rld_dbg_write", mem[30], 16'hBEEF);

    // Reload ignored in LOAD; debug request denied and counted
    reload = 1'b1; dbg_req = 1'b1; #1;
    check("load_dbg_gnt", dbg_gnt, 1'b0);
    tick();
    reload = 1'b0; dbg_req = 1'b0; #1;
    check("load_reload_ign", state_o, 2'd0);
    check("load_wait_cnt", dbg_wait_cnt, 8'd1);

    // 256 words without load_last: wrap-triggered release
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = 16'h5A00 | 16'(i); #1;
      if (i == 255) check("wrap_last_addr", mem_address, 8'hFF);
      tick();
    end
    load_valid = 1'b0; #1;
    check("wrap_state", state_o, 2'd1);
    check("wrap_ptr", mem_address, 8'h00);
    check("wrap_mem255", mem[255], 16'h5AFF);
    check("wrap_mem0", mem[0], 16'h5A00);
    tick();
    check("wrap_run", state_o, 2'd2);

    // Reload, two words, then asynchronous reset mid-LOAD
    reload = 1'b1; tick(); reload = 1'b0;
    load_valid = 1'b1; load_data = 16'h1111; tick();
    load_data = 16'h2222; tick();
    load_data = 16'hFFFF; #1;
    check("pre_rst_addr", mem_address, 8'h02);
    rst = 1'b0; #1;
    check("arst_addr", mem_address, 8'h00);
    check("arst_we", mem_we, 1'b0);
    check("arst_state", state_o, 2'd0);
    check("arst_cpu_rst", cpu_rst, 1'b1);
    tick();
    check("arst_no_write", mem[2], 16'h5A02);
    check("arst_w1", mem[1], 16'h2222);
    load_valid = 1'b0; rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
